// File: rtl/mem_stage_if.sv
// Handshake and data bundle between execute, data SRAM, write-back and the MEM stage.
// The slave modport is the MEM stage's view; master is the surrounding pipeline's view.
interface mem_stage_if;
  logic        ex_to_mem_valid;
  logic        mem_allowin;
  logic [31:0] ex_pc;
  logic [31:0] ex_alu_result;
  logic        ex_res_from_mem;
  logic        ex_rf_we;
  logic        ex_csr_re;
  logic [4:0]  ex_rf_waddr;
  logic        ex_ld_b;
  logic        ex_ld_h;
  logic        ex_ld_u;
  logic        ex_mem_req;
  logic        ex_excep_en;
  logic        ex_ertn_flush;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        flush;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc;
  logic [31:0] mem_rf_wdata;
  logic        mem_rf_we;
  logic [4:0]  mem_rf_waddr;
  logic        mem_excep_en;
  logic        mem_ertn_flush;
  logic        mem_fwd_stall;

  modport slave (
    input  ex_to_mem_valid, ex_pc, ex_alu_result, ex_res_from_mem, ex_rf_we,
           ex_csr_re, ex_rf_waddr, ex_ld_b, ex_ld_h, ex_ld_u, ex_mem_req,
           ex_excep_en, ex_ertn_flush, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_wdata, mem_rf_we,
           mem_rf_waddr, mem_excep_en, mem_ertn_flush, mem_fwd_stall
  );

  modport master (
    output ex_to_mem_valid, ex_pc, ex_alu_result, ex_res_from_mem, ex_rf_we,
           ex_csr_re, ex_rf_waddr, ex_ld_b, ex_ld_h, ex_ld_u, ex_mem_req,
           ex_excep_en, ex_ertn_flush, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_wdata, mem_rf_we,
           mem_rf_waddr, mem_excep_en, mem_ertn_flush, mem_fwd_stall
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, buffers them across
// write-back stalls, aligns load data and drops responses orphaned by a flush.
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  mem_stage_if.slave   bus
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        rf_we;
    logic        csr_re;
    logic [4:0]  rf_waddr;
    logic        ld_b;
    logic        ld_h;
    logic        ld_u;
    logic        excep_en;
    logic        ertn_flush;
  } inst_t;

  logic [1:0]           state_q, state_d;
  logic [DISCARD_W-1:0] disc_cnt_q, disc_cnt_d;
  logic [31:0]          buf_q, buf_d;
  inst_t                inst_q, inst_d;

  logic        own_ok_s;
  logic        ready_go_s;
  logic        allowin_s;
  logic        accept_s;
  logic        leave_s;
  logic        valid_s;
  logic        disc_inc_s;
  logic        disc_dec_s;
  logic [31:0] ld_src_s;
  logic [31:0] ld_data_s;

  function automatic logic [31:0] align_load(
    input logic [31:0] src,
    input logic [1:0]  off,
    input logic        ld_b,
    input logic        ld_h,
    input logic        ld_u
  );
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    case (off)
      2'd0:    byte_v = src[7:0];
      2'd1:    byte_v = src[15:8];
      2'd2:    byte_v = src[23:16];
      2'd3:    byte_v = src[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = off[1] ? src[31:16] : src[15:0];
    if (ld_b) begin
      res_v = {{24{~ld_u & byte_v[7]}}, byte_v};
    end else if (ld_h) begin
      res_v = {{16{~ld_u & half_v[15]}}, half_v};
    end else begin
      res_v = src;
    end
    return res_v;
  endfunction

  // Handshake: a response is ours only once every stale response has drained.
  always_comb begin
    valid_s    = (state_q != S_EMPTY);
    own_ok_s   = bus.data_sram_data_ok & (disc_cnt_q == '0) & (state_q == S_WAIT);
    ready_go_s = (state_q == S_HOLD) | own_ok_s;
    allowin_s  = (state_q == S_EMPTY) | (ready_go_s & bus.wb_allowin);
    accept_s   = bus.ex_to_mem_valid & allowin_s & ~bus.flush;
    leave_s    = valid_s & ready_go_s & bus.wb_allowin;
    disc_inc_s = bus.flush & (state_q == S_WAIT) & ~own_ok_s;
    disc_dec_s = bus.data_sram_data_ok & (disc_cnt_q != '0);
  end

  // Next-state: FSM, stale-response counter, response buffer and latched instruction.
  always_comb begin
    state_d    = state_q;
    disc_cnt_d = disc_cnt_q;
    buf_d      = buf_q;
    inst_d     = inst_q;

    if (bus.flush) begin
      state_d = S_EMPTY;
    end else if (accept_s) begin
      state_d = bus.ex_mem_req ? S_WAIT : S_HOLD;
    end else if (leave_s) begin
      state_d = S_EMPTY;
    end else if (own_ok_s) begin
      state_d = S_HOLD;
    end else begin
      state_d = state_q;
    end

    // An in-flight request orphaned by flush and a drained stale response cancel out.
    case ({disc_inc_s, disc_dec_s})
      2'b10: begin
        if (disc_cnt_q != {DISCARD_W{1'b1}}) begin
          disc_cnt_d = disc_cnt_q + {{(DISCARD_W-1){1'b0}}, 1'b1};
        end else begin
          disc_cnt_d = disc_cnt_q;
        end
      end
      2'b01:   disc_cnt_d = disc_cnt_q - {{(DISCARD_W-1){1'b0}}, 1'b1};
      default: disc_cnt_d = disc_cnt_q;
    endcase

    if (~bus.flush & own_ok_s & ~leave_s) begin
      buf_d = bus.data_sram_rdata;
    end else begin
      buf_d = buf_q;
    end

    if (accept_s) begin
      inst_d.pc           = bus.ex_pc;
      inst_d.alu_result   = bus.ex_alu_result;
      inst_d.res_from_mem = bus.ex_res_from_mem;
      inst_d.rf_we        = bus.ex_rf_we;
      inst_d.csr_re       = bus.ex_csr_re;
      inst_d.rf_waddr     = bus.ex_rf_waddr;
      inst_d.ld_b         = bus.ex_ld_b;
      inst_d.ld_h         = bus.ex_ld_h;
      inst_d.ld_u         = bus.ex_ld_u;
      inst_d.excep_en     = bus.ex_excep_en;
      inst_d.ertn_flush   = bus.ex_ertn_flush;
    end else begin
      inst_d = inst_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      disc_cnt_q <= '0;
      buf_q      <= 32'h0000_0000;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      disc_cnt_q <= disc_cnt_d;
      buf_q      <= buf_d;
      inst_q     <= inst_d;
    end
  end

  // Load alignment: the live response is bypassed in the cycle it arrives.
  always_comb begin
    if (own_ok_s) begin
      ld_src_s = bus.data_sram_rdata;
    end else begin
      ld_src_s = buf_q;
    end
    ld_data_s = align_load(ld_src_s, inst_q.alu_result[1:0],
                           inst_q.ld_b, inst_q.ld_h, inst_q.ld_u);
  end

  // Outputs towards write-back, decode and execute.
  always_comb begin
    bus.mem_allowin     = allowin_s;
    bus.mem_to_wb_valid = valid_s & ready_go_s & ~bus.flush;
    bus.mem_pc          = inst_q.pc;
    bus.mem_rf_wdata    = inst_q.res_from_mem ? ld_data_s : inst_q.alu_result;
    bus.mem_rf_we       = valid_s & inst_q.rf_we;
    bus.mem_rf_waddr    = inst_q.rf_waddr;
    bus.mem_excep_en    = valid_s & inst_q.excep_en;
    bus.mem_ertn_flush  = valid_s & inst_q.ertn_flush;
    bus.mem_fwd_stall   = valid_s & ((inst_q.res_from_mem & ~ready_go_s) | inst_q.csr_re);
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected retirements,
// an independent monitor pops and compares whenever write-back takes an instruction.
module tb_mem_stage;

  logic clk;
  logic reset;
  mem_stage_if bus ();

  mem_stage #(.DISCARD_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wdata;
    logic        we;
    logic [4:0]  waddr;
    logic        excep;
    logic        ertn;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every instruction that write-back accepts against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.mem_to_wb_valid === 1'b1 && bus.wb_allowin === 1'b1) begin
      exp_t act;
      act = '{bus.mem_pc, bus.mem_rf_wdata, bus.mem_rf_we, bus.mem_rf_waddr,
              bus.mem_excep_en, bus.mem_ertn_flush};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_retire: got pc=%h wdata=%h", act.pc, act.wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL retire pc=%h: got wdata=%h we=%b wa=%0d exc=%b ertn=%b expected wdata=%h we=%b wa=%0d exc=%b ertn=%b",
                   e.pc, act.wdata, act.we, act.waddr, act.excep, act.ertn,
                   e.wdata, e.we, e.waddr, e.excep, e.ertn);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    bus.ex_to_mem_valid = 1'b0;
    bus.ex_mem_req      = 1'b0;
    bus.ex_excep_en     = 1'b0;
    bus.ex_ertn_flush   = 1'b0;
    bus.ex_csr_re       = 1'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] alu,
                       input logic res_mem, input logic we, input logic csr,
                       input logic [4:0] wa, input logic b, input logic h,
                       input logic u, input logic req, input logic exc,
                       input logic ertn);
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_pc           = pc;
    bus.ex_alu_result   = alu;
    bus.ex_res_from_mem = res_mem;
    bus.ex_rf_we        = we;
    bus.ex_csr_re       = csr;
    bus.ex_rf_waddr     = wa;
    bus.ex_ld_b         = b;
    bus.ex_ld_h         = h;
    bus.ex_ld_u         = u;
    bus.ex_mem_req      = req;
    bus.ex_excep_en     = exc;
    bus.ex_ertn_flush   = ertn;
  endtask

  task automatic expect_ret(input logic [31:0] pc, input logic [31:0] wd,
                            input logic we, input logic [4:0] wa,
                            input logic exc, input logic ertn);
    exp_q.push_back('{pc, wd, we, wa, exc, ertn});
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = rd;
  endtask

  task automatic no_resp();
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0BAD_0BAD;
  endtask

  initial begin
    reset = 1'b1;
    clear_ex();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_to_mem_valid = 1'b0;
    no_resp();
    bus.flush      = 1'b0;
    bus.wb_allowin = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("reset_allowin", 32'(bus.mem_allowin), 32'd1);
    chk("reset_valid",   32'(bus.mem_to_wb_valid), 32'd0);
    chk("reset_wdata",   bus.mem_rf_wdata, 32'h0);
    chk("reset_stall",   32'(bus.mem_fwd_stall), 32'd0);
    step();
    reset = 1'b0;

    // ld.b signed, response in first cycle, bypassed
    drive(32'h100, 32'h1003, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ret(32'h100, 32'hFFFF_FF80, 1'b1, 5'd3, 1'b0, 1'b0);
    step();
    clear_ex();
    respond(32'h80FF_1234);
    @(negedge clk);
    chk("ldb_bypass_valid", 32'(bus.mem_to_wb_valid), 32'd1);
    chk("ldb_bypass_stall", 32'(bus.mem_fwd_stall), 32'd0);
    step();
    no_resp();

    // ld.bu
    drive(32'h104, 32'h1003, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_ret(32'h104, 32'h0000_0080, 1'b1, 5'd4, 1'b0, 1'b0);
    step();
    clear_ex();
    respond(32'h80FF_1234);
    step();
    no_resp();

    // ld.h with late response and a write-back stall
    drive(32'h108, 32'h2002, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ret(32'h108, 32'hFFFF_ABCD, 1'b1, 5'd5, 1'b0, 1'b0);
    step();
    clear_ex();
    bus.wb_allowin = 1'b0;
    @(negedge clk);
    chk("ldh_c1_stall", 32'(bus.mem_fwd_stall), 32'd1);
    chk("ldh_c1_valid", 32'(bus.mem_to_wb_valid), 32'd0);
    step();
    respond(32'hABCD_0000);
    @(negedge clk);
    chk("ldh_c2_stall", 32'(bus.mem_fwd_stall), 32'd0);
    chk("ldh_c2_allowin", 32'(bus.mem_allowin), 32'd0);
    step();
    no_resp();
    @(negedge clk);
    chk("ldh_c3_stall", 32'(bus.mem_fwd_stall), 32'd0);
    chk("ldh_c3_wdata_buf", bus.mem_rf_wdata, 32'hFFFF_ABCD);
    step();
    bus.wb_allowin = 1'b1;
    step();

    // flush while waiting: one stale response must be discarded
    drive(32'h200, 32'h3000, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_ex();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_valid", 32'(bus.mem_to_wb_valid), 32'd0);
    step();
    bus.flush = 1'b0;
    step();
    drive(32'h204, 32'h3004, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ret(32'h204, 32'h1111_2222, 1'b1, 5'd7, 1'b0, 1'b0);
    step();
    clear_ex();
    respond(32'hDEAD_BEEF);
    @(negedge clk);
    chk("stale_drop_valid", 32'(bus.mem_to_wb_valid), 32'd0);
    chk("stale_drop_stall", 32'(bus.mem_fwd_stall), 32'd1);
    step();
    respond(32'h1111_2222);
    step();
    no_resp();

    // flush together with a response: nothing retires, no stale count left behind
    drive(32'h300, 32'h4000, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_ex();
    respond(32'h9999_9999);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_ok_valid", 32'(bus.mem_to_wb_valid), 32'd0);
    step();
    bus.flush = 1'b0;
    no_resp();
    drive(32'h304, 32'h4004, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ret(32'h304, 32'h5566_7788, 1'b1, 5'd9, 1'b0, 1'b0);
    step();
    clear_ex();
    respond(32'h5566_7788);
    step();
    no_resp();

    // input arriving with flush is not accepted
    drive(32'h400, 32'h0000_0011, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    step();
    clear_ex();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_input_dropped", 32'(bus.mem_to_wb_valid), 32'd0);
    step();

    // exception and ertn pass through in one cycle
    drive(32'h500, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_ret(32'h500, 32'hCAFE_0000, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    clear_ex();
    @(negedge clk);
    chk("excep_flag", 32'(bus.mem_excep_en), 32'd1);
    step();
    drive(32'h504, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_ret(32'h504, 32'h0000_1234, 1'b0, 5'd0, 1'b0, 1'b1);
    step();
    clear_ex();
    step();

    // back-to-back ALU ops, last one reads a CSR
    for (int i = 0; i < 4; i++) begin
      drive(32'h600 + 32'(4 * i), 32'h7000_0000 + 32'(i), 1'b0, 1'b1, (i == 3),
            5'(11 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_ret(32'h600 + 32'(4 * i), 32'h7000_0000 + 32'(i), 1'b1, 5'(11 + i), 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_allowin", 32'(bus.mem_allowin), 32'd1);
      step();
    end
    clear_ex();
    @(negedge clk);
    chk("csr_fwd_stall", 32'(bus.mem_fwd_stall), 32'd1);
    step();
    step();
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back. It holds one instruction per cycle, waits for the data-SRAM response of any load or store that execute issued, and captures that response in a one-entry buffer when write-back stalls. It aligns and extends load data, forwards results and stall hints to decode, and reports exception and ertn state back to execute. After a flush it discards any data-SRAM responses that are still in flight.

## Interface
- DISCARD_W, 2: width of the stale-response discard counter, which saturates at 2^DISCARD_W-1.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ex_to_mem_valid  in  1  execute holds a valid instruction that is ready to advance.
- mem_allowin  out  1  MEM accepts a new instruction this cycle.
- ex_pc  in  32  PC of the incoming instruction.
- ex_alu_result  in  32  ALU result, or the memory address for loads and stores.
- ex_res_from_mem, ex_rf_we, ex_csr_re  in  1 each  load flag, register-write flag, CSR-read flag.
- ex_rf_waddr  in  5  destination register.
- ex_ld_b, ex_ld_h, ex_ld_u  in  1 each  byte load, halfword load, zero-extend; all three low means a word load.
- ex_mem_req  in  1  execute issued a data-SRAM request and the address was accepted.
- ex_excep_en, ex_ertn_flush  in  1 each  instruction carries an exception, or is an ertn.
- data_sram_data_ok  in  1  response strobe, one per accepted request, returned in order.
- data_sram_rdata  in  32  read data; valid only when data_ok is high.
- flush  in  1  pipeline flush from write-back.
- wb_allowin  in  1  write-back accepts this cycle.
- mem_to_wb_valid  out  1  MEM instruction is complete and valid.
- mem_pc, mem_rf_wdata  out  32 each  PC and final write-back data.
- mem_rf_we  out  1  register write, qualified by valid.
- mem_rf_waddr  out  5  destination register.
- mem_excep_en, mem_ertn_flush  out  1 each  exception and ertn flags, qualified by valid; these also go to execute to block its memory requests.
- mem_fwd_stall  out  1  decode must stall consumers of mem_rf_waddr.

## Operation
- FSM states:
  - EMPTY: no instruction held.
  - WAIT: a request is outstanding and no data has been received yet.
  - HOLD: complete; either no request was issued or the data is buffered.
- Accept when ex_to_mem_valid & mem_allowin & ~flush. The next state is WAIT if ex_mem_req is set, otherwise HOLD.
- A data_ok "belongs to MEM" only if disc_cnt==0 and the state is WAIT. Any data_ok while disc_cnt>0 decrements disc_cnt and is otherwise ignored.
- WAIT with a data_ok that belongs to MEM: rdata is captured into buf and the FSM goes to HOLD, unless the instruction leaves MEM in the same cycle.
- ready_go = (state==HOLD) | (state==WAIT & data_ok that belongs to MEM).
- mem_allowin = (state==EMPTY) | (ready_go & wb_allowin).
- mem_to_wb_valid = (state!=EMPTY) & ready_go & ~flush.
- Load data source: the live rdata in the bypass cycle, otherwise buf. Lane selection uses off = alu_result[1:0]:
  - byte load: byte[off]; sign-extended unless ld_u.
  - halfword load: off[1] ? [31:16] : [15:0]; sign-extended unless ld_u.
  - word load: all 32 bits.
- mem_rf_wdata = res_from_mem ? aligned load data : alu_result.
- mem_fwd_stall = valid & ((res_from_mem & ~ready_go) | csr_re).
- Flush: the FSM goes to EMPTY. If the state was WAIT and the owned data_ok is not arriving that cycle, disc_cnt increments (saturating). If a data_ok arrives that same cycle, it is consumed by whichever party owns it and disc_cnt does not increment.
- An instruction carrying ex_excep_en or ex_ertn_flush arrives with ex_mem_req=0 and goes straight to HOLD.

## Timing
- Reset values:
  - state EMPTY, disc_cnt 0, buf 0, all latched fields 0.
  - Every output is 0 except mem_allowin, which is 1.
- Minimum MEM occupancy is 1 cycle: either no request, or data_ok arrives in the first cycle and is bypassed combinationally to mem_rf_wdata.
- With a late data_ok, the instruction leaves in the cycle data_ok arrives if wb_allowin is high. Otherwise it leaves in the first later cycle with wb_allowin high, using buf.
- If flush and data_ok arrive together in WAIT, the data is dropped and disc_cnt stays unchanged.
- If flush and a new input arrive together, the input is not accepted.
- A new instruction issued while disc_cnt>0 waits until all stale responses are consumed, then takes the next data_ok.
- Reset asserted mid-WAIT returns everything to reset values; responses still in flight after reset are the bus's responsibility.

## Test plan
- Load without WB stall: ld.b, addr 0x1003, rdata 0x80FF_1234, data_ok in the first cycle -> mem_to_wb_valid in the same cycle and mem_rf_wdata 0xFFFF_FF80. With ld_u set -> 0x0000_0080.
- WB stall: ld.h, addr 0x2002, data_ok in cycle 2 with rdata 0xABCD_0000, wb_allowin low for 3 cycles -> state HOLD; after wb_allowin rises, mem_rf_wdata 0xFFFF_ABCD. mem_fwd_stall is high only in cycle 1.
- Flush in WAIT: load waiting, flush in cycle 1 -> disc_cnt 1. Next load accepted in cycle 3. First data_ok (rdata 0xDEAD_BEEF) is discarded. Second data_ok (0x1111_2222) -> mem_rf_wdata 0x1111_2222.
- Flush together with data_ok: no valid to WB and disc_cnt stays 0.
- Exception passthrough: ex_excep_en=1, ex_mem_req=0 -> leaves in 1 cycle. mem_excep_en is high while valid, and mem_rf_wdata equals alu_result.
- Back-to-back non-memory ALU ops with wb_allowin constantly high -> one instruction retires per cycle and mem_allowin stays high throughout.
